// File: rtl/cpu_pkg.sv
// Shared opcode encodings, flag bit positions and opcode classification
// for the 8-bit pipeline.
package cpu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_NOT = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_ASR = 5'b01010;
  localparam logic [4:0] OP_ROL = 5'b01100;
  localparam logic [4:0] OP_ROR = 5'b01101;
  localparam logic [4:0] OP_RCL = 5'b01110;
  localparam logic [4:0] OP_RCR = 5'b01111;
  localparam logic [4:0] OP_LD  = 5'b10000;
  localparam logic [4:0] OP_ST  = 5'b10001;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_INC = 5'b11001;
  localparam logic [4:0] OP_DEC = 5'b11010;
  localparam logic [4:0] OP_NEG = 5'b11011;

  localparam int unsigned FLG_P = 3;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 0;

  // Opcodes whose execute result is written back to the register file.
  function automatic logic is_wb_op(input logic [4:0] op);
    logic r;
    case (op) inside
      [OP_ADD:OP_ADC], [OP_AND:OP_NOT], [OP_SHL:OP_ASR], [OP_ROL:OP_RCR],
      OP_IN, [OP_INC:OP_NEG]: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_flag_op(input logic [4:0] op);
    return is_wb_op(op);
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: synchronous write, combinational read, and a
// synchronous active-low clear of the whole array.
module data_mem #(
  parameter int unsigned DM_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [DM_AW-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** DM_AW;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: data-memory access, architectural flag register
// and the registered register-file write port.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DM_AW = 5,
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [4:0]       op_mem,
  input  logic [RF_AW-1:0] rd_mem,
  input  logic [7:0]       ans_ex,
  input  logic [7:0]       DM_data,
  input  logic [3:0]       flag_ex,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic [3:0]       flags
);

  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [7:0]       rf_wdata_q, rf_wdata_d;
  logic [3:0]       flags_q, flags_d;

  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [7:0]       dm_rdata;

  // Upper address bits are dropped so accesses wrap around the array.
  assign dm_addr = ans_ex[DM_AW-1:0];
  assign dm_we   = valid_in && (op_mem == OP_ST);

  data_mem #(
    .DM_AW(DM_AW)
  ) u_data_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (dm_we),
    .addr_i  (dm_addr),
    .wdata_i (DM_data),
    .rdata_o (dm_rdata)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    flags_d    = flags_q;
    if (valid_in) begin
      if (op_mem == OP_LD) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = rd_mem;
        rf_wdata_d = dm_rdata;
      end else if (is_wb_op(op_mem)) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = rd_mem;
        rf_wdata_d = ans_ex;
      end
      if (is_flag_op(op_mem)) begin
        flags_d = flag_ex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= 8'h00;
      flags_q    <= 4'h0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flags_q    <= flags_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed scenarios then random traffic
// against a behavioural model of the stage.
module tb_mem_wb_stage;

  localparam int unsigned DM_AW = 5;
  localparam int unsigned RF_AW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [4:0]       op_mem;
  logic [RF_AW-1:0] rd_mem;
  logic [7:0]       ans_ex;
  logic [7:0]       DM_data;
  logic [3:0]       flag_ex;
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [7:0]       rf_wdata;
  logic [3:0]       flags;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DM_AW(DM_AW),
    .RF_AW(RF_AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .op_mem   (op_mem),
    .rd_mem   (rd_mem),
    .ans_ex   (ans_ex),
    .DM_data  (DM_data),
    .flag_ex  (flag_ex),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .flags    (flags)
  );

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] waddr;
    logic [7:0]       wdata;
    logic [3:0]       flg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0]       m_dm [32];
  logic [RF_AW-1:0] m_waddr;
  logic [7:0]       m_wdata;
  logic [3:0]       m_flags;
  int               wb_list[18] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 15, 22, 25, 26, 27};

  function automatic bit in_wb_list(input logic [4:0] op);
    foreach (wb_list[i]) if (wb_list[i] == int'(op)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model and queue the expected outputs.
  task automatic issue(input bit rst_n, input bit v, input logic [4:0] op,
                       input logic [7:0] ans, input logic [7:0] data,
                       input logic [3:0] flg, input logic [RF_AW-1:0] rd);
    exp_t e;
    int a;
    reset = rst_n; valid_in = v; op_mem = op; ans_ex = ans;
    DM_data = data; flag_ex = flg; rd_mem = rd;
    a = int'(ans) % 32;
    e.we = 1'b0;
    if (!rst_n) begin
      foreach (m_dm[i]) m_dm[i] = 8'h00;
      m_waddr = '0; m_wdata = 8'h00; m_flags = 4'h0;
    end else if (v) begin
      if (op == 5'b10001) begin
        m_dm[a] = data;
      end else if (op == 5'b10000) begin
        e.we = 1'b1; m_waddr = rd; m_wdata = m_dm[a];
      end else if (in_wb_list(op)) begin
        e.we = 1'b1; m_waddr = rd; m_wdata = ans; m_flags = flg;
      end
    end
    e.waddr = m_waddr; e.wdata = m_wdata; e.flg = m_flags;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so each edge retires one queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", {7'b0, rf_we}, {7'b0, e.we});
        chk("rf_waddr", {5'b0, rf_waddr}, {5'b0, e.waddr});
        chk("rf_wdata", rf_wdata, e.wdata);
        chk("flags", {4'b0, flags}, {4'b0, e.flg});
      end
    end
  end

  initial begin
    int budget;
    // Reset with a store pending, then load the same address.
    issue(0, 1, 5'b10001, 8'h03, 8'hAA, 4'hF, 3'd1);
    issue(0, 1, 5'b10001, 8'h03, 8'hAA, 4'hF, 3'd1);
    issue(1, 1, 5'b10000, 8'h03, 8'h00, 4'h0, 3'd4);
    // ALU write-back.
    issue(1, 1, 5'b00000, 8'h5A, 8'h00, 4'b0100, 3'd2);
    // Store then load.
    issue(1, 1, 5'b10001, 8'h07, 8'hC3, 4'hF, 3'd6);
    issue(1, 1, 5'b10000, 8'h07, 8'h00, 4'hF, 3'd5);
    // Address wrap.
    issue(1, 1, 5'b10001, 8'h27, 8'h11, 4'h0, 3'd0);
    issue(1, 1, 5'b10000, 8'h07, 8'h00, 4'h0, 3'd3);
    // Flag hold.
    issue(1, 1, 5'b00001, 8'h33, 8'h00, 4'b1011, 3'd7);
    issue(1, 1, 5'b10111, 8'h44, 8'h00, 4'b0000, 3'd1);
    issue(1, 0, 5'b00000, 8'h55, 8'h00, 4'b0000, 3'd2);
    // Reset mid-stream over a store, then load it back.
    issue(1, 1, 5'b10001, 8'h09, 8'h77, 4'h0, 3'd0);
    issue(0, 1, 5'b10001, 8'h0A, 8'h66, 4'h0, 3'd0);
    issue(1, 1, 5'b10000, 8'h0A, 8'h00, 4'h0, 3'd6);
    issue(1, 1, 5'b10000, 8'h09, 8'h00, 4'h0, 3'd5);
    // Random traffic, weighted toward memory ops so loads hit earlier stores.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      case ($urandom_range(0, 3))
        0:       op = 5'b10001;
        1:       op = 5'b10000;
        default: op = 5'($urandom_range(0, 31));
      endcase
      issue(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) != 0), op,
            8'($urandom), 8'($urandom), 4'($urandom), 3'($urandom));
    end
    valid_in = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
